// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Opcodes, FSM state encoding and helpers shared by the ALU.
// Revision: 1.0
// ============================================================================
package alu_pkg;

    localparam logic [3:0] c_op_and   = 4'd0;
    localparam logic [3:0] c_op_or    = 4'd1;
    localparam logic [3:0] c_op_xor   = 4'd2;
    localparam logic [3:0] c_op_nor   = 4'd3;
    localparam logic [3:0] c_op_add   = 4'd4;
    localparam logic [3:0] c_op_sll   = 4'd5;
    localparam logic [3:0] c_op_srl   = 4'd6;
    localparam logic [3:0] c_op_sra   = 4'd7;
    localparam logic [3:0] c_op_sub   = 4'd8;
    localparam logic [3:0] c_op_slt   = 4'd9;
    localparam logic [3:0] c_op_sltu  = 4'd10;
    localparam logic [3:0] c_op_mul   = 4'd11;
    localparam logic [3:0] c_op_mulhu = 4'd12;
    localparam logic [3:0] c_op_divu  = 4'd13;
    localparam logic [3:0] c_op_remu  = 4'd14;
    localparam logic [3:0] c_op_rsvd  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    typedef enum logic [1:0] {
        MD_MUL   = 2'd0,
        MD_MULHU = 2'd1,
        MD_DIVU  = 2'd2,
        MD_REMU  = 2'd3
    } md_op_t;

    function automatic logic is_iter_op(input logic [3:0] fs);
        return (fs == c_op_mul) || (fs == c_op_mulhu) ||
               (fs == c_op_divu) || (fs == c_op_remu);
    endfunction

    function automatic md_op_t md_op_of(input logic [3:0] fs);
        md_op_t v_op;
        case (fs)
            c_op_mulhu: v_op = MD_MULHU;
            c_op_divu:  v_op = MD_DIVU;
            c_op_remu:  v_op = MD_REMU;
            default:    v_op = MD_MUL;
        endcase
        return v_op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module  : alu_muldiv_iter
// Brief   : Radix-2 shift-add multiplier / restoring divider, WIDTH steps.
// Revision: 1.0
// ============================================================================
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] c_last_step = CW'(WIDTH - 1);

    // hi/lo hold {product high, product low} for MUL, {remainder, quotient} for DIV
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    md_op_t           r_op;

    logic             w_is_div;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_fit;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;

    always_comb begin
        w_is_div  = (r_op == MD_DIVU) || (r_op == MD_REMU);
        w_add     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
        w_shift   = {r_hi, r_lo[WIDTH-1]};
        w_fit     = (w_shift >= {1'b0, r_b});
        w_diff    = w_shift[WIDTH-1:0] - r_b;
        w_hi_next = w_add[WIDTH:1];
        w_lo_next = {w_add[0], r_lo[WIDTH-1:1]};
        if (w_is_div) begin
            w_hi_next = w_fit ? w_diff : w_shift[WIDTH-1:0];
            w_lo_next = {r_lo[WIDTH-2:0], w_fit};
        end
        // The top captures the value being written on the final step edge
        case (r_op)
            MD_MULHU: result = w_hi_next;
            MD_REMU:  result = w_hi_next;
            default:  result = w_lo_next;
        endcase
        last = r_busy && (r_cnt == c_last_step);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_op   <= MD_MUL;
        end else if (start) begin
            r_hi   <= '0;
            r_lo   <= a;
            r_b    <= b;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_op   <= op;
        end else if (r_busy) begin
            r_hi <= w_hi_next;
            r_lo <= w_lo_next;
            if (last) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module  : alu_mc
// Brief   : Multi-cycle ALU: single-cycle logic/arith/shift, iterative mul/div.
// Revision: 1.0
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    input  logic [3:0]       FS,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic [3:0]       status
);

    alu_state_t       r_state;
    alu_state_t       w_state_next;
    logic [WIDTH-1:0] r_f;
    logic [3:0]       r_status;

    logic             w_start;
    logic             w_capture_alu;
    logic             w_capture_md;
    logic             w_md_last;
    logic [WIDTH-1:0] w_md_result;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_f;
    logic             w_v;
    logic             w_c;

    // Single-cycle datapath, evaluated on the live inputs at the accept edge
    always_comb begin
        w_sh  = B[SHW-1:0];
        w_sum = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C0};
        w_dif = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        w_f   = '0;
        w_v   = 1'b0;
        w_c   = 1'b0;
        case (FS)
            c_op_and: w_f = A & B;
            c_op_or:  w_f = A | B;
            c_op_xor: w_f = A ^ B;
            c_op_nor: w_f = ~(A | B);
            c_op_add: begin
                w_f = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_v = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            c_op_sll: w_f = A << w_sh;
            c_op_srl: w_f = A >> w_sh;
            c_op_sra: w_f = $signed(A) >>> w_sh;
            c_op_sub: begin
                w_f = w_dif[WIDTH-1:0];
                w_c = w_dif[WIDTH];
                w_v = (A[WIDTH-1] != B[WIDTH-1]) && (w_dif[WIDTH-1] != A[WIDTH-1]);
            end
            c_op_slt:  w_f = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            c_op_sltu: w_f = {{(WIDTH-1){1'b0}}, (A < B)};
            default:   w_f = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_start       = 1'b0;
        w_capture_alu = 1'b0;
        w_capture_md  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_iter_op(FS)) begin
                        w_start      = 1'b1;
                        w_state_next = ST_CALC;
                    end else begin
                        w_capture_alu = 1'b1;
                        w_state_next  = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                if (w_md_last) begin
                    w_capture_md = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_f      <= '0;
            r_status <= '0;
        end else if (w_capture_alu) begin
            r_f      <= w_f;
            r_status <= {w_v, w_c, w_f[WIDTH-1], (w_f == '0)};
        end else if (w_capture_md) begin
            r_f      <= w_md_result;
            r_status <= {2'b00, w_md_result[WIDTH-1], (w_md_result == '0)};
        end
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (w_start),
        .op     (md_op_of(FS)),
        .a      (A),
        .b      (B),
        .last   (w_md_last),
        .result (w_md_result)
    );

    // in_ready is gated by rst so no operation is offered while reset is held
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_DONE);
    assign F         = r_f;
    assign status    = r_status;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_mc
// Brief   : Scoreboard bench for alu_mc with a behavioural reference model.
// Revision: 1.0
// ============================================================================
module tb_alu_mc;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          C0;
    logic [3:0]    FS;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  F;
    logic [3:0]    status;

    int checks   = 0;
    int failures = 0;
    logic [35:0] sb_q[$];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C0        (C0),
        .FS        (FS),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .F         (F),
        .status    (status)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {V,C,N,Z,F} computed from integer arithmetic
    function automatic logic [35:0] model(input logic [3:0] fs, input logic [31:0] a,
                                          input logic [31:0] b, input logic c0);
        longint unsigned ua, ub, t;
        longint          sa, sb, s;
        int              sv;
        logic [31:0]     f;
        logic            v, c;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sv = $signed(a);
        v = 1'b0;
        c = 1'b0;
        case (fs)
            4'd0:  f = a & b;
            4'd1:  f = a | b;
            4'd2:  f = a ^ b;
            4'd3:  f = ~(a | b);
            4'd4: begin
                t = ua + ub + (c0 ? 64'd1 : 64'd0);
                f = t[31:0];
                c = t[32];
                s = sa + sb;
                if (c0) s = s + 1;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd5:  f = a << b[4:0];
            4'd6:  f = a >> b[4:0];
            4'd7:  f = sv >>> b[4:0];
            4'd8: begin
                f = a - b;
                c = (ua >= ub);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd9:  f = (sa < sb) ? 32'd1 : 32'd0;
            4'd10: f = (ua < ub) ? 32'd1 : 32'd0;
            4'd11: begin t = ua * ub; f = t[31:0];  end
            4'd12: begin t = ua * ub; f = t[63:32]; end
            4'd13: f = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd14: f = (b == 0) ? a : a % b;
            default: f = 32'd0;
        endcase
        return {v, c, f[31], (f == 32'd0), f};
    endfunction

    // Monitor: compare each new result against the scoreboard, then check it holds
    logic        mon_seen = 1'b0;
    logic [35:0] mon_last;
    always @(negedge clk) begin
        logic [35:0] exp_v;
        if (rst || !out_valid) begin
            mon_seen = 1'b0;
        end else if (!mon_seen) begin
            mon_seen = 1'b1;
            mon_last = {status, F};
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", {status, F});
            end else begin
                exp_v = sb_q.pop_front();
                chk("result", {28'd0, status, F}, {28'd0, exp_v});
            end
        end else begin
            chk("done_hold", {28'd0, status, F}, {28'd0, mon_last});
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL wait_in_ready: got 0 expected 1 after %0d cycles", n);
        end
    endtask

    task automatic do_op(input logic [3:0] fs, input logic [31:0] a, input logic [31:0] b,
                         input logic c0, input int hold);
        int lat;
        int exp_lat;
        wait_ready();
        in_valid = 1'b1;
        FS = fs; A = a; B = b; C0 = c0;
        sb_q.push_back(model(fs, a, b, c0));
        exp_lat = (fs >= 4'd11 && fs <= 4'd14) ? W + 1 : 1;
        @(negedge clk);
        lat = 1;
        forever begin
            // Junk inputs while busy must be ignored
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            FS = 4'($urandom); A = $urandom; B = $urandom; C0 = 1'($urandom);
            if (out_valid || lat >= W + 10) break;
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b0;
            chk("done_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release", {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; C0 = 1'b0; FS = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset_f_status", {28'd0, status, F}, 64'd0);
        rst = 1'b0;
        #1;
        chk("reset_release_in_ready", {63'd0, in_ready}, 64'd1);

        do_op(4'd4,  32'h7FFF_FFFF, 32'd1, 1'b0, 0);
        do_op(4'd8,  32'd5, 32'd5, 1'b0, 0);
        do_op(4'd7,  32'h8000_0000, 32'h21, 1'b0, 1);
        do_op(4'd11, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
        do_op(4'd12, 32'hFFFF_FFFF, 32'd2, 1'b0, 0);
        do_op(4'd13, 32'd100, 32'd0, 1'b0, 0);
        do_op(4'd14, 32'd100, 32'd0, 1'b0, 2);
        do_op(4'd13, 32'd100, 32'd7, 1'b0, 5);
        do_op(4'd14, 32'd100, 32'd7, 1'b0, 0);
        do_op(4'd4,  32'hFFFF_FFFF, 32'd0, 1'b1, 0);
        do_op(4'd15, 32'h1234_5678, 32'd9, 1'b1, 0);

        // Abort a DIVU at CALC cycle 10; no result may appear
        wait_ready();
        in_valid = 1'b1; FS = 4'd13; A = 32'd100; B = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_f_status", {28'd0, status, F}, 64'd0);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (40) @(negedge clk);
        chk("abort_no_result", {63'd0, out_valid}, 64'd0);
        do_op(4'd4, 32'd2, 32'd3, 1'b0, 0);

        for (int k = 0; k < 150; k++) begin
            do_op(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom),
                  $urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
